// File: rtl/sipo_deframer.sv
// sipo_deframer: serial-to-parallel receive stage fed by the PISO serializer.
//
// Rebuilds LSB-first serial words of WIDTH bits (bit 0 flagged by sof) into
// parallel words and queues them in a 2-entry FIFO with a valid/ready
// handshake toward the consuming PE. Framing errors and overflow drops raise
// sticky flags.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   s_in       serial data bit (bit 0 of a word arrives first)
//   s_valid    s_in carries a bit this cycle
//   sof        qualified by s_valid: this bit is bit 0 of a new word
//   clr_err    synchronous clear of frame_err / ovf_err
//   p_out      head-of-queue word
//   out_valid  queue not empty
//   out_ready  consumer accepts p_out
//   level      queue occupancy, 0..2
//   frame_err  sticky: word aborted by an early sof
//   ovf_err    sticky: completed word dropped because the queue was full
//   busy       word assembly in progress

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module sipo_deframer #(
    parameter int WIDTH = `DATA_WIDTH*2,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             sof,
    input  logic             clr_err,
    output logic [WIDTH-1:0] p_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       level,
    output logic             frame_err,
    output logic             ovf_err,
    output logic             busy
);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    // Only the upper WIDTH-1 bits need storage: the completing bit goes
    // straight into the queue together with these, so no bubble is needed.
    logic [WIDTH-2:0]   r_sr,    w_sr_nxt;
    logic [WIDTH-1:0]   w_word;
    logic               w_push;
    logic               w_frame_ev;

    logic [WIDTH-1:0]   r_q0, r_q1;
    logic [1:0]         r_level;
    logic               r_frame_err, r_ovf_err;
    logic               w_pop, w_ovf_ev;

    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign w_word = {s_in, r_sr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sr    <= w_sr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sr_nxt    = r_sr;
        w_push      = 1'b0;
        w_frame_ev  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Bits outside a frame are silently ignored.
                if (s_valid && sof) begin
                    w_sr_nxt    = w_word[WIDTH-1:1];
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (s_valid) begin
                    w_sr_nxt = w_word[WIDTH-1:1];
                    if (sof) begin
                        // Early sof: drop the partial word, restart on this bit.
                        w_frame_ev = 1'b1;
                        w_cnt_nxt  = CNT_W'(1);
                    end else if (r_cnt == CNT_W'(WIDTH-1)) begin
                        w_push      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output queue: r_q0 is always the head, r_q1 the second entry.
    assign w_pop    = (r_level != 2'd0) && out_ready;
    assign w_ovf_ev = w_push && (r_level == 2'd2) && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q0    <= '0;
            r_q1    <= '0;
            r_level <= 2'd0;
        end else begin
            case (r_level)
                2'd0: begin
                    if (w_push) begin
                        r_q0    <= w_word;
                        r_level <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_q0 <= w_word;
                    end else if (w_push) begin
                        r_q1    <= w_word;
                        r_level <= 2'd2;
                    end else if (w_pop) begin
                        r_level <= 2'd0;
                    end
                end
                default: begin
                    // Full: a push only lands when the head leaves this cycle.
                    if (w_pop) begin
                        r_q0 <= r_q1;
                        if (w_push) r_q1    <= w_word;
                        else        r_level <= 2'd1;
                    end
                end
            endcase
        end
    end

    // Sticky flags: an event in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_frame_err <= (r_frame_err && !clr_err) || w_frame_ev;
            r_ovf_err   <= (r_ovf_err   && !clr_err) || w_ovf_ev;
        end
    end

    assign p_out     = r_q0;
    assign out_valid = (r_level != 2'd0);
    assign level     = r_level;
    assign frame_err = r_frame_err;
    assign ovf_err   = r_ovf_err;
    assign busy      = (r_state == S_SHIFT);

endmodule

// File: tb/tb_sipo_deframer.sv
// Testbench for sipo_deframer (WIDTH=32): directed scenarios followed by
// random traffic, every cycle compared against a word-level model built from
// bit positions and a SystemVerilog queue.

module tb_sipo_deframer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_in, s_valid, sof, clr_err, out_ready;
    logic [W-1:0]  p_out;
    logic          out_valid;
    logic [1:0]    level;
    logic          frame_err, ovf_err, busy;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0]  m_q[$];
    logic [W-1:0]  m_word;
    int            m_nbits;
    bit            m_busy, m_fe, m_ovf;

    sipo_deframer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .sof(sof),
        .clr_err(clr_err), .p_out(p_out), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .frame_err(frame_err),
        .ovf_err(ovf_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_q.delete();
        m_word  = '0;
        m_nbits = 0;
        m_busy  = 0;
        m_fe    = 0;
        m_ovf   = 0;
    endfunction

    // One clock edge worth of specified behaviour.
    function automatic void m_step(bit sv, bit si, bit sf, bit clr, bit rdy);
        bit pop, push, fe_ev, ovf_ev;
        logic [W-1:0] done;
        int pre;
        pop = (m_q.size() > 0) && rdy;
        push = 0; fe_ev = 0; ovf_ev = 0; done = '0;
        if (sv) begin
            if (sf) begin
                if (m_busy) fe_ev = 1;
                m_busy = 1; m_word = '0; m_word[0] = si; m_nbits = 1;
            end else if (m_busy) begin
                m_word[m_nbits] = si;
                m_nbits++;
                if (m_nbits == W) begin
                    push = 1; done = m_word; m_busy = 0; m_nbits = 0;
                end
            end
        end
        pre = m_q.size();
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (pre == 2 && !pop) ovf_ev = 1;
            else m_q.push_back(done);
        end
        m_fe  = (m_fe  && !clr) || fe_ev;
        m_ovf = (m_ovf && !clr) || ovf_ev;
    endfunction

    task automatic check_all();
        chk("out_valid", W'(out_valid), W'(m_q.size() > 0));
        chk("level", W'(level), W'(m_q.size()));
        if (m_q.size() > 0) chk("p_out", p_out, m_q[0]);
        chk("frame_err", W'(frame_err), W'(m_fe));
        chk("ovf_err", W'(ovf_err), W'(m_ovf));
        chk("busy", W'(busy), W'(m_busy));
    endtask

    task automatic cyc(input bit sv, input bit si, input bit sf, input bit clr, input bit rdy);
        s_valid = sv; s_in = si; sof = sf; clr_err = clr; out_ready = rdy;
        @(posedge clk);
        m_step(sv, si, sf, clr, rdy);
        #1;
        check_all();
    endtask

    // Full word, continuous s_valid; rdy_last applies only to the final bit.
    task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit rdy_last);
        for (int i = 0; i < W; i++)
            cyc(1'b1, w[i], i == 0, 1'b0, (i == W-1) ? rdy_last : rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        logic [W-1:0] x;
        rst = 1'b0; s_in = 0; s_valid = 0; sof = 0; clr_err = 0; out_ready = 0;
        m_reset();
        #12;
        chk("rst p_out", p_out, '0);
        check_all();
        @(negedge clk) rst = 1'b1;

        // Single word, consumer always ready: visible the cycle after bit 31.
        send_word(32'hA5A50F0F, 1'b1, 1'b1);
        chk("word1 valid", W'(out_valid), W'(1));
        chk("word1 data", p_out, 32'hA5A50F0F);
        idle(1, 1'b1);
        chk("word1 drained", W'(level), W'(0));

        // Stray bits while idle, then word 1 with s_valid toggling.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        x = 32'h1;
        for (int i = 0; i < W; i++) begin
            cyc(1'b1, x[i], i == 0, 1'b0, 1'b1);
            if (i != W-1) begin
                cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
                chk("toggle busy", W'(busy), W'(1));
            end
        end
        chk("toggle data", p_out, 32'h1);
        idle(2, 1'b1);

        // Aborted word then 0x12345678: frame_err set, then cleared.
        x = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) cyc(1'b1, x[i], i == 0, 1'b0, 1'b0);
        send_word(32'h12345678, 1'b0, 1'b0);
        chk("abort fe", W'(frame_err), W'(1));
        chk("abort data", p_out, 32'h12345678);
        chk("abort level", W'(level), W'(1));
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr fe", W'(frame_err), W'(0));

        // Overflow: three words, consumer stalled.
        send_word(32'h1, 1'b0, 1'b0);
        send_word(32'h2, 1'b0, 1'b0);
        send_word(32'h3, 1'b0, 1'b0);
        chk("ovf level", W'(level), W'(2));
        chk("ovf flag", W'(ovf_err), W'(1));
        chk("ovf head", p_out, 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf pop2", p_out, 32'h2);
        idle(1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Full queue, pop coincides with third completion: no drop.
        send_word(32'h1, 1'b0, 1'b0);
        send_word(32'h2, 1'b0, 1'b0);
        send_word(32'h3, 1'b0, 1'b1);
        chk("pp ovf", W'(ovf_err), W'(0));
        chk("pp level", W'(level), W'(2));
        chk("pp head", p_out, 32'h2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pp last", p_out, 32'h3);
        idle(1, 1'b1);

        // Async reset mid-word with one word queued.
        send_word(32'hCAFEF00D, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, i == 0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        m_reset();
        chk("arst p_out", p_out, '0);
        check_all();
        @(negedge clk) rst = 1'b1;
        send_word(32'h0BADCAFE, 1'b1, 1'b1);
        chk("post-rst data", p_out, 32'h0BADCAFE);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 2) != 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Serial-to-parallel receive stage directly downstream of the PISO serializer; its input is the PISO serial output.
- Reassembles LSB-first serial words of WIDTH bits, framed by a start-of-word strobe, into parallel words.
- Buffers completed words in a 2-entry output queue with a valid/ready handshake toward the consuming PE.
- Flags framing errors and overflow with sticky status bits.

Parameters:
- WIDTH, default `DATA_WIDTH*2, bits per serial word; must be >= 2.
- CNT_W, default $clog2(WIDTH), width of the bit counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- s_in  in  1  serial data bit; bit 0 of each word arrives first
- s_valid  in  1  s_in carries a bit this cycle (mirrors PISO load|ce)
- sof  in  1  qualified by s_valid; this bit is bit 0 of a new word
- clr_err  in  1  synchronous clear of sticky error flags
- p_out  out  WIDTH  head-of-queue word
- out_valid  out  1  queue not empty
- out_ready  in  1  consumer accepts p_out
- level  out  2  queue occupancy, 0..2
- frame_err  out  1  sticky: word aborted by early sof
- ovf_err  out  1  sticky: completed word dropped, queue full
- busy  out  1  word assembly in progress (state SHIFT)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, bit counter 0, shift register 0, queue empty, p_out=0, out_valid=0, level=0, frame_err=0, ovf_err=0, busy=0. Mid-word reset discards the partial word and all queued words.
- State IDLE:
  - s_valid&sof: load s_in into shift-register MSB; counter=1; go to SHIFT.
  - s_valid&!sof: bit ignored; no flag.
- State SHIFT:
  - Each s_valid&!sof: shift register shifts right, s_in enters the MSB; counter+1.
  - The accepted bit with counter==WIDTH-1 completes the word. The shift register then holds bit0..bit(WIDTH-1) in natural order. Push the word into the queue; go to IDLE; counter=0.
  - s_valid&sof in SHIFT: partial word discarded; frame_err<=1; restart with this bit as bit 0, counter=1, stay in SHIFT.
  - s_valid=0: hold; no timeout.
- WIDTH==... completion check uses the pre-increment counter. A sof bit is never itself a completing bit, since WIDTH>=2.
- Latency: the completing bit is sampled at edge N. With the queue empty, out_valid=1 and p_out=word after edge N, i.e. zero bubble. Back-to-back words with no gap are supported at full rate.
- Queue: 2-entry FIFO, first-in first-out; p_out always shows the oldest entry and is stable while out_valid&!out_ready.
  - Pop on out_valid&out_ready.
  - Push with level==2 and no pop: word dropped, ovf_err<=1, queue unchanged.
  - Push with level==2 and simultaneous pop: push accepted, level stays 2.
  - Push and pop at level==1: level stays 1; p_out shows the new word next cycle.
  - Pop at level 0 is impossible, since out_valid=0.
- p_out resets to 0 but is don't-care when out_valid=0.
- clr_err clears both sticky flags. If an error event occurs in the same cycle as clr_err, the event wins and the flag reads 1.
- busy = (state==SHIFT).

Test Plan:
- WIDTH=32, out_ready=1: send 0xA5A50F0F LSB-first, sof on bit 0, s_valid continuous -> out_valid high exactly the cycle after bit 31, p_out=0xA5A50F0F, level returns 0.
- Bits with s_valid toggling 1,0,1,0 -> word 0x00000001 reassembles correctly; busy high from bit 0 until completion; idle-cycle bits ignored.
- sof reasserted after 10 bits of word X, then a full word 0x12345678 -> frame_err=1; only 0x12345678 emerges; clr_err -> frame_err=0.
- out_ready=0, three back-to-back words 0x1,0x2,0x3 -> level=2, ovf_err=1; the next two pops return 0x1 then 0x2.
- Queue full, out_ready=1 in the same cycle the third word completes -> no ovf_err; pops return 0x1, 0x2, 0x3 in order.
- rst pulled low asynchronously mid-word with level=1 -> all outputs immediately 0. After release, a fresh word is received correctly.
